// File: rtl/jpeg_udp_packetizer.sv
// JPEG frame-buffer reader that splits a frame into UDP payloads for mac_top.
// Each payload starts with a 4-byte header: frame id, packet index, flags.
module jpeg_udp_packetizer #(
  parameter int ADDR_W      = 20,
  parameter int MAX_PAYLOAD = 1024,
  parameter int HDR_BYTES   = 4,
  parameter int GAP_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_mac_init_ready,
  input  logic              I_frame_valid,
  input  logic [ADDR_W-1:0] I_frame_base,
  input  logic [ADDR_W-1:0] I_frame_len,
  output logic              O_frame_ack,
  output logic              O_rd_en,
  output logic [ADDR_W-1:0] O_rd_addr,
  input  logic [7:0]        I_rd_data,
  output logic              O_udp_tx_en,
  output logic [7:0]        O_udp_data,
  output logic [15:0]       O_udp_data_len,
  output logic [15:0]       O_ipv4_sign,
  input  logic              I_udp_busy,
  input  logic              I_udp_isLoadData,
  output logic              O_busy,
  output logic              O_err,
  output logic [7:0]        O_frame_id
);

  typedef enum logic [2:0] {
    IDLE, WAIT_MAC, START, LOAD, GAP, DONE
  } state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_PAYLOAD);
  localparam logic [15:0] HDR_W = 16'(HDR_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] pay_a;
  logic [15:0]       pkt_idx;
  logic [15:0]       pay;
  logic [15:0]       byte_idx;
  logic [15:0]       rd_cnt;
  logic [15:0]       data_len;
  logic [15:0]       ipv4_sign;
  logic [7:0]        frame_id;
  logic [GW-1:0]     gap_cnt;
  logic              len_zero;
  logic              last_pkt;
  logic              busy_seen;
  logic              err_q;

  logic accept, load_pay, ld;
  logic last_byte, abort, gap_run, rd_fire;

  assign ld      = I_udp_isLoadData;
  assign pay_a   = (remaining > MAX_A) ? MAX_A : remaining;
  assign last_byte = (state == LOAD) && ld &&
                     (byte_idx == data_len - 16'd1);
  // Busy may rise a few cycles after tx_en, so only a fall after it was seen counts.
  assign abort   = (state == LOAD) && !ld &&
                   ((byte_idx != 16'd0) || (busy_seen && !I_udp_busy));
  assign gap_run = (state == GAP) &&
                   !(I_udp_busy && (gap_cnt == '0));
  assign rd_fire = (state == LOAD) && ld &&
                   (byte_idx >= HDR_W - 16'd1) && (rd_cnt < pay);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load_pay = 1'b0;
    unique case (state)
      IDLE: begin
        if (I_frame_valid && I_mac_init_ready) begin
          accept   = 1'b1;
          state_nx = (I_frame_len == '0) ? DONE : WAIT_MAC;
        end
      end
      WAIT_MAC: begin
        if (!I_udp_busy) begin
          load_pay = 1'b1;
          state_nx = START;
        end
      end
      START: state_nx = LOAD;
      LOAD: begin
        if (last_byte)  state_nx = GAP;
        else if (abort) state_nx = DONE;
      end
      GAP: begin
        if (gap_run && (gap_cnt == GAP_LAST))
          state_nx = (remaining != '0) ? WAIT_MAC : DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      pkt_idx   <= '0;
      pay       <= '0;
      byte_idx  <= '0;
      rd_cnt    <= '0;
      data_len  <= '0;
      ipv4_sign <= '0;
      frame_id  <= '0;
      gap_cnt   <= '0;
      len_zero  <= 1'b0;
      last_pkt  <= 1'b0;
      busy_seen <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= abort;
      if (accept) begin
        addr      <= I_frame_base;
        remaining <= I_frame_len;
        pkt_idx   <= '0;
        len_zero  <= (I_frame_len == '0);
      end
      if (load_pay) begin
        pay       <= 16'(pay_a);
        data_len  <= 16'(pay_a) + HDR_W;
        last_pkt  <= (remaining == pay_a);
        byte_idx  <= '0;
        rd_cnt    <= '0;
        busy_seen <= 1'b0;
      end
      if ((state == START || state == LOAD) && I_udp_busy)
        busy_seen <= 1'b1;
      if (state == LOAD && ld)
        byte_idx <= byte_idx + 16'd1;
      if (rd_fire) begin
        addr   <= addr + 1'b1;
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (last_byte) begin
        remaining <= remaining - ADDR_W'(pay);
        pkt_idx   <= pkt_idx + 16'd1;
        ipv4_sign <= ipv4_sign + 16'd1;
      end
      if (gap_run)
        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
      if (state == DONE && !len_zero)
        frame_id <= frame_id + 8'd1;
    end
  end

  always_comb begin
    O_udp_data = I_rd_data;
    if (byte_idx < HDR_W) begin
      unique case (byte_idx[1:0])
        2'd0:    O_udp_data = frame_id;
        2'd1:    O_udp_data = pkt_idx[15:8];
        2'd2:    O_udp_data = pkt_idx[7:0];
        default: O_udp_data = {6'd0, pkt_idx == 16'd0, last_pkt};
      endcase
    end
  end

  assign O_busy         = (state != IDLE);
  assign O_udp_tx_en    = (state == START);
  assign O_frame_ack    = (state == DONE);
  assign O_err          = err_q;
  assign O_rd_en        = rd_fire;
  assign O_rd_addr      = addr;
  assign O_udp_data_len = data_len;
  assign O_ipv4_sign    = ipv4_sign;
  assign O_frame_id     = frame_id;

endmodule
